// File: rtl/masked_sync_mem.sv
// Lane-masked 1W/1R memory: registered write-first read, post-reset zero-fill.
// Optional single-address shadow checker enabled by defining MEM_TRACK_EN.
module masked_sync_mem #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_wrEna,
    input  logic [LANES-1:0]           io_wrMask,
    input  logic [ADDR_W-1:0]          io_wrAddr,
    input  logic [LANE_W*LANES-1:0]    io_wrData,
    input  logic                       io_rdEna,
    input  logic [ADDR_W-1:0]          io_rdAddr,
    output logic [LANE_W*LANES-1:0]    io_rdData,
    output logic                       io_rdValid,
`ifdef MEM_TRACK_EN
    input  logic [ADDR_W-1:0]          io_trkAddr,
    output logic                       io_trkMismatch,
`endif
    output logic                       io_busy
);

    localparam int DATA_W = LANE_W * LANES;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd_word;
    logic                wr_acc;
    logic                rd_acc;
    logic                same_addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_acc     = (state_q == READY) && io_wrEna;
        rd_acc     = (state_q == READY) && io_rdEna;
        same_addr  = (io_wrAddr == io_rdAddr);
        wr_merged  = mem_q[io_wrAddr];
        rd_word    = mem_q[io_rdAddr];
        for (int i = 0; i < LANES; i++) begin
            if (io_wrMask[i]) begin
                wr_merged[i*LANE_W +: LANE_W] = io_wrData[i*LANE_W +: LANE_W];
                // write-first: only the lanes being written are forwarded
                if (wr_acc && same_addr)
                    rd_word[i*LANE_W +: LANE_W] = io_wrData[i*LANE_W +: LANE_W];
            end
        end
        mem_we = wr_acc;
        mem_wa = io_wrAddr;
        mem_wd = wr_merged;
        unique case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) state_d = READY;
            end
            READY: begin
            end
            default: state_d = CLEAR;
        endcase
        if (rd_acc) rd_data_d = rd_word;
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign io_rdData  = rd_data_q;
    assign io_rdValid = rd_valid_q;
    assign io_busy    = (state_q == CLEAR);

`ifdef MEM_TRACK_EN
    logic [ADDR_W-1:0]   trk_addr_q, trk_addr_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                chk_q, chk_d;
    logic                mism_q, mism_d;

    always_comb begin
        trk_addr_d = trk_addr_q;
        shadow_d   = shadow_q;
        if (state_q == CLEAR && (&cnt_q)) trk_addr_d = io_trkAddr;
        if (wr_acc && io_wrAddr == trk_addr_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (io_wrMask[i])
                    shadow_d[i*LANE_W +: LANE_W] = io_wrData[i*LANE_W +: LANE_W];
            end
        end
        // shadow_d already includes any same-cycle forwarded lanes
        exp_d  = shadow_d;
        chk_d  = rd_acc && (io_rdAddr == trk_addr_q);
        mism_d = mism_q | (chk_q && (rd_data_q != exp_q));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trk_addr_q <= '0;
            shadow_q   <= '0;
            exp_q      <= '0;
            chk_q      <= 1'b0;
            mism_q     <= 1'b0;
        end else begin
            trk_addr_q <= trk_addr_d;
            shadow_q   <= shadow_d;
            exp_q      <= exp_d;
            chk_q      <= chk_d;
            mism_q     <= mism_d;
        end
    end

    assign io_trkMismatch = mism_d;
`endif

endmodule

// File: tb/tb_masked_sync_mem.sv
// Directed-vector bench for masked_sync_mem (default 8x4 lanes, 1024 words).
// Tracker vectors run only when MEM_TRACK_EN is defined.
module tb_masked_sync_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_wrEna;
    logic [3:0]  io_wrMask;
    logic [9:0]  io_wrAddr;
    logic [31:0] io_wrData;
    logic        io_rdEna;
    logic [9:0]  io_rdAddr;
    logic [31:0] io_rdData;
    logic        io_rdValid;
    logic        io_busy;
`ifdef MEM_TRACK_EN
    logic [9:0]  io_trkAddr;
    logic        io_trkMismatch;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    masked_sync_mem dut (
        .clock      (clock),
        .reset      (reset),
        .io_wrEna   (io_wrEna),
        .io_wrMask  (io_wrMask),
        .io_wrAddr  (io_wrAddr),
        .io_wrData  (io_wrData),
        .io_rdEna   (io_rdEna),
        .io_rdAddr  (io_rdAddr),
        .io_rdData  (io_rdData),
        .io_rdValid (io_rdValid),
`ifdef MEM_TRACK_EN
        .io_trkAddr     (io_trkAddr),
        .io_trkMismatch (io_trkMismatch),
`endif
        .io_busy    (io_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        io_wrEna = 1'b1; io_wrAddr = a; io_wrData = d; io_wrMask = m;
        tick;
        io_wrEna = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [9:0] a,
                      input logic [31:0] exp);
        io_rdEna = 1'b1; io_rdAddr = a;
        tick;
        io_rdEna = 1'b0;
        check({tag, "_data"}, io_rdData, exp);
        check({tag, "_vld"}, {31'b0, io_rdValid}, 32'd1);
    endtask

    // Counts busy cycles from the release point; optionally hammers
    // requests that must all be ignored while clearing.
    task automatic clear_wait(input string tag, input bit hammer);
        int n = 0;
        bit saw_vld = 1'b0;
        while (io_busy && n < 2000) begin
            if (hammer) begin
                io_wrEna = 1'b1; io_wrMask = 4'hF;
                io_wrAddr = 10'd0; io_wrData = 32'hFFFF_FFFF;
                io_rdEna = 1'b1; io_rdAddr = 10'd0;
            end
            n++;
            tick;
            if (io_rdValid) saw_vld = 1'b1;
        end
        io_wrEna = 1'b0;
        io_rdEna = 1'b0;
        check({tag, "_len"}, n, 32'd1024);
        if (hammer) check({tag, "_rdvld"}, {31'b0, saw_vld}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        io_wrEna = 1'b0; io_wrMask = '0; io_wrAddr = '0; io_wrData = '0;
        io_rdEna = 1'b0; io_rdAddr = '0;
`ifdef MEM_TRACK_EN
        io_trkAddr = 10'd42;
`endif
        tick; tick;
        check("rst_data", io_rdData, 32'h0);
        check("rst_vld", {31'b0, io_rdValid}, 32'd0);
        check("rst_busy", {31'b0, io_busy}, 32'd1);
`ifdef MEM_TRACK_EN
        check("rst_trk", {31'b0, io_trkMismatch}, 32'd0);
`endif
        reset = 1'b0;
        clear_wait("clr1", 1'b0);

        rd("z0", 10'd0, 32'h0);
        rd("z511", 10'd511, 32'h0);
        rd("z1023", 10'd1023, 32'h0);

        wr(10'd5, 32'hAABB_CCDD, 4'b1111);
        wr(10'd5, 32'h1122_3344, 4'b0101);
        rd("mask", 10'd5, 32'hAA22_CC44);
        wr(10'd5, 32'h9999_9999, 4'b0000);
        rd("mask0", 10'd5, 32'hAA22_CC44);

        io_wrEna = 1'b1; io_wrAddr = 10'd7; io_wrData = 32'hDEAD_BEEF;
        io_wrMask = 4'b0011;
        rd("fwd", 10'd7, 32'h0000_BEEF);
        rd("fwd_after", 10'd7, 32'h0000_BEEF);

        io_wrEna = 1'b1; io_wrAddr = 10'd9; io_wrData = 32'h0000_0055;
        io_wrMask = 4'b1111;
        rd("indep", 10'd5, 32'hAA22_CC44);
        rd("indep_w", 10'd9, 32'h0000_0055);

        wr(10'd3, 32'h1234_5678, 4'hF);
        rd("hold_src", 10'd3, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("hold_data", io_rdData, 32'h1234_5678);
            check("hold_vld", {31'b0, io_rdValid}, 32'd0);
        end

        reset = 1'b1; tick; reset = 1'b0;
        repeat (300) tick;
        reset = 1'b1; tick; reset = 1'b0;
        clear_wait("clr2", 1'b1);
        rd("gate0", 10'd0, 32'h0);
        rd("gate5", 10'd5, 32'h0);
        rd("gate3", 10'd3, 32'h0);

`ifdef MEM_TRACK_EN
        wr(10'd42, 32'h0F0F_0F0F, 4'hF);
        rd("trk_ok", 10'd42, 32'h0F0F_0F0F);
        check("trk_ok_flag", {31'b0, io_trkMismatch}, 32'd0);
        dut.mem_q[42] = 32'hFFFF_FFFF;
        rd("trk_bad", 10'd42, 32'hFFFF_FFFF);
        check("trk_bad_flag", {31'b0, io_trkMismatch}, 32'd1);
        tick; tick;
        check("trk_sticky", {31'b0, io_trkMismatch}, 32'd1);
        reset = 1'b1; tick;
        check("trk_rst", {31'b0, io_trkMismatch}, 32'd0);
        reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
